// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code decoder.
package ps2_pkg;

  // Set-2 prefix bytes.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Protocol, ack and error bytes that never form a key event.
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // FIFO pop sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StGap,
    StDecode
  } pop_state_e;

  // True for bytes that cancel any pending prefix and produce no event.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_fifo_popper.sv
// Pops one byte at a time from the keyboard FIFO with a timed, registered
// nextdata_n strobe, then presents the latched byte for one decode cycle.
module ps2_fifo_popper
  import ps2_pkg::*;
#(
  parameter int unsigned POP_CYCLES = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_ready,
  input  logic [7:0] kb_data,
  output logic       nextdata_n,
  output logic       byte_valid,
  output logic [7:0] byte_r
);

  localparam int unsigned CntMax = (POP_CYCLES > GAP_CYCLES) ? POP_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] PopLast = CntW'(POP_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

  pop_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic            nextdata_n_q, nextdata_n_d;
  logic            byte_valid_q, byte_valid_d;

  // Next-state: the byte is latched on the same edge ready is seen, so a
  // falling ready during POP/GAP cannot lose it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    nextdata_n_d = nextdata_n_q;
    case (state_q)
      StIdle: begin
        if (kb_ready) begin
          byte_d       = kb_data;
          cnt_d        = '0;
          nextdata_n_d = 1'b0;
          state_d      = StPop;
        end
      end
      StPop: begin
        if (cnt_q == PopLast) begin
          cnt_d        = '0;
          nextdata_n_d = 1'b1;
          state_d      = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        // Gives the keyboard time to advance before ready is looked at again.
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StDecode;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDecode: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    byte_valid_d = (state_d == StDecode);
  end

  // Sequencer state and registered strobes; nextdata_n is a flop so it is glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      byte_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign nextdata_n = nextdata_n_q;
  assign byte_valid = byte_valid_q;
  assign byte_r     = byte_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns raw set-2 scan-code bytes into single-cycle key events and tracks the
// held key, typematic repeats, a press counter and a sticky overflow flag.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned POP_CYCLES = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_repeat,
  output logic       held_valid,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] press_cnt,
  output logic       ovf_seen
);

  logic       byte_valid;
  logic [7:0] byte_r;

  ps2_fifo_popper #(
    .POP_CYCLES(POP_CYCLES),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_popper (
    .clk       (clk),
    .rst       (rst),
    .kb_ready  (kb_ready),
    .kb_data   (kb_data),
    .nextdata_n(nextdata_n),
    .byte_valid(byte_valid),
    .byte_r    (byte_r)
  );

  logic       ext_f_q, ext_f_d;
  logic       brk_f_q, brk_f_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_release_q, key_release_d;
  logic       key_repeat_q, key_repeat_d;
  logic       held_valid_q, held_valid_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_ext_q, held_ext_d;
  logic [7:0] press_cnt_q, press_cnt_d;
  logic       ovf_seen_q, ovf_seen_d;
  logic       held_match;

  // Decode the byte in the DECODE cycle; prefixes only update flags.
  always_comb begin
    ext_f_d       = ext_f_q;
    brk_f_d       = brk_f_q;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    key_repeat_d  = key_repeat_q;
    held_valid_d  = held_valid_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    press_cnt_d   = press_cnt_q;
    ovf_seen_d    = ovf_seen_q | kb_overflow;
    held_match    = held_valid_q && (held_ext_q == ext_f_q) && (held_code_q == byte_r);

    if (byte_valid) begin
      if (byte_r == PS2_EXT) begin
        ext_f_d = 1'b1;
      end else if (byte_r == PS2_BRK) begin
        brk_f_d = 1'b1;
      end else if (is_ignored(byte_r)) begin
        ext_f_d = 1'b0;
        brk_f_d = 1'b0;
      end else begin
        key_valid_d   = 1'b1;
        key_code_d    = byte_r;
        key_ext_d     = ext_f_q;
        key_release_d = brk_f_q;
        if (brk_f_q) begin
          // Breaks are never repeats; only the held key's break releases it.
          key_repeat_d = 1'b0;
          if (held_match) begin
            held_valid_d = 1'b0;
          end
        end else if (held_match) begin
          key_repeat_d = 1'b1;
        end else begin
          key_repeat_d = 1'b0;
          press_cnt_d  = press_cnt_q + 8'd1;
          held_valid_d = 1'b1;
          held_code_d  = byte_r;
          held_ext_d   = ext_f_q;
        end
        ext_f_d = 1'b0;
        brk_f_d = 1'b0;
      end
    end
  end

  // Event, held-key and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_f_q       <= 1'b0;
      brk_f_q       <= 1'b0;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_repeat_q  <= 1'b0;
      held_valid_q  <= 1'b0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
      press_cnt_q   <= 8'h00;
      ovf_seen_q    <= 1'b0;
    end else begin
      ext_f_q       <= ext_f_d;
      brk_f_q       <= brk_f_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
      key_repeat_q  <= key_repeat_d;
      held_valid_q  <= held_valid_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      press_cnt_q   <= press_cnt_d;
      ovf_seen_q    <= ovf_seen_d;
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;
  assign key_repeat  = key_repeat_q;
  assign held_valid  = held_valid_q;
  assign held_code   = held_code_q;
  assign held_ext    = held_ext_q;
  assign press_cnt   = press_cnt_q;
  assign ovf_seen    = ovf_seen_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a byte-queue keyboard FIFO model, table-driven
// byte sequences, and hand-written latency/overflow/reset/wrap sequences.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_repeat;
  logic       held_valid;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] press_cnt;
  logic       ovf_seen;

  ps2_key_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .kb_data    (kb_data),
    .kb_ready   (kb_ready),
    .kb_overflow(kb_overflow),
    .nextdata_n (nextdata_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_release(key_release),
    .key_repeat (key_repeat),
    .held_valid (held_valid),
    .held_code  (held_code),
    .held_ext   (held_ext),
    .press_cnt  (press_cnt),
    .ovf_seen   (ovf_seen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Keyboard FIFO model: pops on the first low cycle of nextdata_n.
  logic [7:0] fifo_q[$];
  logic       nd_prev = 1'b1;
  int         nd_low_cnt = 0;
  int         ready_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (!nextdata_n && nd_prev && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (!nextdata_n) nd_low_cnt++;
    nd_prev = nextdata_n;
    if (fifo_q.size() > 0) begin
      if (!kb_ready) ready_cyc = cyc + 1;
      kb_ready = 1'b1;
      kb_data  = fifo_q[0];
    end else begin
      kb_ready = 1'b0;
      kb_data  = 8'h00;
    end
  end

  // Event monitor.
  int         ev_n = 0;
  int         kv_cyc = 0;
  logic [7:0] ev_code = 8'h00;
  logic       ev_ext = 1'b0, ev_rel = 1'b0, ev_rep = 1'b0;

  initial forever begin
    @(negedge clk);
    if (key_valid === 1'b1) begin
      ev_n++;
      kv_cyc  = cyc;
      ev_code = key_code;
      ev_ext  = key_ext;
      ev_rel  = key_release;
      ev_rep  = key_repeat;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_q.delete();
    repeat (2) @(posedge clk);
    ev_n       = 0;
    nd_low_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait for the model FIFO to empty, then let the last byte finish decoding.
  task automatic drain(input string name, input int limit);
    int t;
    t = 0;
    while (fifo_q.size() != 0 && t < limit) begin
      @(posedge clk);
      t++;
    end
    check({name, ".drain_timeout"}, 32'(t >= limit), 32'd0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    string            name;
    int               nb;
    logic [0:5][7:0]  b;
    int               nev;
    logic [7:0]       code;
    logic             ext;
    logic             rel;
    logic             rep;
    logic             hv;
    logic [7:0]       hc;
    logic             he;
    logic [7:0]       cnt;
  } vec_t;

  vec_t vt[9];

  initial begin
    // name, nbytes, bytes, events, last{code,ext,rel,rep}, held{v,code,ext}, press_cnt
    vt[0] = '{"make1C",   1, {8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1,
              8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'h01};
    vt[1] = '{"typematic", 4, {8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00}, 3,
              8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C, 1'b0, 8'h01};
    vt[2] = '{"ext_E0F0", 5, {8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h00}, 2,
              8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 8'h01};
    vt[3] = '{"ext_F0E0", 5, {8'hE0, 8'h75, 8'hF0, 8'hE0, 8'h75, 8'h00}, 2,
              8'h75, 1'b1, 1'b1, 1'b0, 1'b0, 8'h75, 1'b1, 8'h01};
    vt[4] = '{"brk_other", 4, {8'h1C, 8'h32, 8'hF0, 8'h1C, 8'h00, 8'h00}, 3,
              8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h32, 1'b0, 8'h02};
    vt[5] = '{"ignored",  5, {8'hAA, 8'hFA, 8'hE0, 8'hFA, 8'h1C, 8'h00}, 1,
              8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'h01};
    vt[6] = '{"brk_twice", 3, {8'hF0, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00}, 1,
              8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[7] = '{"ext_vs_plain", 3, {8'hE0, 8'h1C, 8'h1C, 8'h00, 8'h00, 8'h00}, 2,
              8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'h02};
    vt[8] = '{"ext_repeat", 4, {8'hE0, 8'h1C, 8'hE0, 8'h1C, 8'h00, 8'h00}, 2,
              8'h1C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b1, 8'h01};

    // Reset state.
    apply_reset();
    @(negedge clk);
    check("rst.nextdata_n", 32'(nextdata_n), 32'd1);
    check("rst.key_valid", 32'(key_valid), 32'd0);
    check("rst.key_fields", {28'd0, key_ext, key_release, key_repeat, 1'b0}, 32'd0);
    check("rst.key_code", 32'(key_code), 32'd0);
    check("rst.held", {23'd0, held_valid, held_code}, 32'd0);
    check("rst.held_ext", 32'(held_ext), 32'd0);
    check("rst.press_cnt", 32'(press_cnt), 32'd0);
    check("rst.ovf_seen", 32'(ovf_seen), 32'd0);

    // Single-byte latency and pop strobe width.
    fifo_q.push_back(8'h1C);
    drain("latency", 200);
    check("latency.cycles", 32'(kv_cyc - ready_cyc + 1), 32'd5);
    check("latency.nd_low_cycles", 32'(nd_low_cnt), 32'd1);
    check("latency.events", 32'(ev_n), 32'd1);

    // Table-driven byte sequences, each from reset.
    for (int i = 0; i < 9; i++) begin
      apply_reset();
      for (int k = 0; k < vt[i].nb; k++) fifo_q.push_back(vt[i].b[k]);
      drain(vt[i].name, 500);
      check({vt[i].name, ".events"}, 32'(ev_n), 32'(vt[i].nev));
      check({vt[i].name, ".code"}, 32'(ev_code), 32'(vt[i].code));
      check({vt[i].name, ".ext"}, 32'(ev_ext), 32'(vt[i].ext));
      check({vt[i].name, ".release"}, 32'(ev_rel), 32'(vt[i].rel));
      check({vt[i].name, ".repeat"}, 32'(ev_rep), 32'(vt[i].rep));
      check({vt[i].name, ".held_valid"}, 32'(held_valid), 32'(vt[i].hv));
      check({vt[i].name, ".held_code"}, 32'(held_code), 32'(vt[i].hc));
      check({vt[i].name, ".held_ext"}, 32'(held_ext), 32'(vt[i].he));
      check({vt[i].name, ".press_cnt"}, 32'(press_cnt), 32'(vt[i].cnt));
    end

    // Sticky overflow.
    apply_reset();
    check("ovf.before", 32'(ovf_seen), 32'd0);
    @(negedge clk);
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    repeat (6) @(negedge clk);
    check("ovf.sticky", 32'(ovf_seen), 32'd1);

    // Reset asserted while nextdata_n is low.
    apply_reset();
    fifo_q.push_back(8'h1C);
    drain("midpop.setup", 200);
    check("midpop.setup_cnt", 32'(press_cnt), 32'd1);
    fifo_q.push_back(8'h32);
    begin
      int t;
      t = 0;
      while (nextdata_n !== 1'b0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("midpop.wait_pop_timeout", 32'(t >= 50), 32'd0);
    end
    #1;
    rst = 1'b0;
    fifo_q.delete();
    #1;
    check("midpop.nextdata_n", 32'(nextdata_n), 32'd1);
    check("midpop.key_code", 32'(key_code), 32'd0);
    check("midpop.held", {23'd0, held_valid, held_code}, 32'd0);
    check("midpop.press_cnt", 32'(press_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 256 distinct make/break pairs wrap the press counter.
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] code;
      code = 8'((i % 128) + 1);
      if (i >= 128) fifo_q.push_back(8'hE0);
      fifo_q.push_back(code);
      if (i >= 128) fifo_q.push_back(8'hE0);
      fifo_q.push_back(8'hF0);
      fifo_q.push_back(code);
    end
    drain("wrap", 30000);
    check("wrap.events", 32'(ev_n), 32'd512);
    check("wrap.press_cnt", 32'(press_cnt), 32'd0);
    check("wrap.held_valid", 32'(held_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
